// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC
// [-> MEM] -> WB -> FETCH, with a sticky TRAP state for illegal encodings.
// Optional build macro RV32I_CTRL_INSTRET_EN adds a retired-instruction
// counter output (instret) that counts WB cycles.
module rv32i_multicycle_ctrl #(
  parameter int RESET_STATE_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  dmem_size,
  output logic        load_unsigned,
  output logic [4:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        illegal,
  output logic [2:0]  state
`ifdef RV32I_CTRL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP
  } cls_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] DLY_INIT = 2'(RESET_STATE_DELAY);

  state_t     state_q;
  cls_t       cls_q;
  logic [2:0] f3_q;
  logic [1:0] dly_q;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;
  logic       dec_legal;
  cls_t       dec_cls;
  logic [4:0] dec_op;
  logic [1:0] dec_src_a;
  logic       dec_src_b;

  // Only the opcode, funct3 and funct7[5] steer control; the rest belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // ALU function for OP / OP-IMM; funct7[5] selects SUB only for register forms.
  function automatic logic [4:0] arith_op(input logic [2:0] fn3, input logic alt,
                                          input logic is_reg);
    case (fn3)
      3'b000:  arith_op = (is_reg && alt) ? 5'd18 : 5'd2;
      3'b001:  arith_op = 5'd15;
      3'b010,
      3'b011:  arith_op = 5'd11;
      3'b100:  arith_op = 5'd12;
      3'b101:  arith_op = alt ? 5'd17 : 5'd16;
      3'b110:  arith_op = 5'd13;
      default: arith_op = 5'd14;
    endcase
  endfunction

  assign opc  = instr[6:0];
  assign f3   = instr[14:12];
  assign f7b5 = instr[30];

  // Decode the instruction register while in DECODE: legality, class and EXEC controls.
  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_OP;
    dec_op    = 5'd2;
    dec_src_a = 2'd0;
    dec_src_b = 1'b1;
    case (opc)
      OPC_LUI:   begin dec_cls = C_LUI;   dec_op = 5'd0; dec_src_a = 2'd2; end
      OPC_AUIPC: begin dec_cls = C_AUIPC; dec_op = 5'd1; dec_src_a = 2'd1; end
      OPC_JAL:   begin dec_cls = C_JAL;   dec_src_a = 2'd1; end
      OPC_JALR:  dec_cls = C_JALR;
      OPC_BRANCH: begin
        dec_cls   = C_BRANCH;
        dec_src_b = 1'b0;
        case (f3)
          3'b001:         dec_op = 5'd4;
          3'b100, 3'b110: dec_op = 5'd5;
          3'b101, 3'b111: dec_op = 5'd6;
          default:        dec_op = 5'd3;
        endcase
      end
      OPC_LOAD: begin
        dec_cls   = C_LOAD;
        dec_legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OPC_STORE: begin
        dec_cls   = C_STORE;
        dec_legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      end
      OPC_OPIMM: begin
        dec_cls   = C_OPIMM;
        dec_op    = arith_op(f3, f7b5, 1'b0);
        dec_legal = !(f3 == 3'b001 && f7b5);
      end
      OPC_OP: begin
        dec_cls   = C_OP;
        dec_op    = arith_op(f3, f7b5, 1'b1);
        dec_src_b = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Fetch request is held off during reset and for the post-reset idle window.
  assign imem_req = (state_q == S_FETCH) && (dly_q == 2'd0) && !rst;
  assign ir_write = imem_req && imem_ready;
  assign state    = state_q;

  // Sequencer: state, latched instruction class and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      dly_q         <= DLY_INIT;
      cls_q         <= C_OP;
      f3_q          <= 3'd0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_size     <= 2'd0;
      load_unsigned <= 1'b0;
      alu_op        <= 5'd0;
      alu_src_a     <= 2'd0;
      alu_src_b     <= 1'b0;
      reg_write     <= 1'b0;
      wb_sel        <= 2'd0;
      pc_write      <= 1'b0;
      pc_sel        <= 2'd0;
      illegal       <= 1'b0;
    end else begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_size     <= 2'd0;
      load_unsigned <= 1'b0;
      alu_op        <= 5'd0;
      alu_src_a     <= 2'd0;
      alu_src_b     <= 1'b0;
      reg_write     <= 1'b0;
      wb_sel        <= 2'd0;
      pc_write      <= 1'b0;
      pc_sel        <= 2'd0;
      case (state_q)
        S_FETCH: begin
          if (dly_q != 2'd0) dly_q <= dly_q - 2'd1;
          else if (imem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (dec_legal) begin
            state_q   <= S_EXEC;
            cls_q     <= dec_cls;
            f3_q      <= f3;
            alu_op    <= dec_op;
            alu_src_a <= dec_src_a;
            alu_src_b <= dec_src_b;
          end else begin
            state_q <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (cls_q == C_LOAD || cls_q == C_STORE) begin
            state_q       <= S_MEM;
            dmem_req      <= 1'b1;
            dmem_we       <= (cls_q == C_STORE);
            dmem_size     <= f3_q[1:0];
            load_unsigned <= f3_q[2];
          end else begin
            // Branch outcome is captured from alu_zero here, straight into pc_sel.
            state_q   <= S_WB;
            pc_write  <= 1'b1;
            reg_write <= (cls_q != C_BRANCH);
            wb_sel    <= (cls_q == C_JAL || cls_q == C_JALR) ? 2'd2 : 2'd0;
            if (cls_q == C_JAL || cls_q == C_JALR) pc_sel <= 2'd1;
            else if (cls_q == C_BRANCH && alu_zero) pc_sel <= 2'd2;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state_q   <= S_WB;
            pc_write  <= 1'b1;
            reg_write <= (cls_q == C_LOAD);
            wb_sel    <= (cls_q == C_LOAD) ? 2'd1 : 2'd0;
          end else begin
            dmem_req      <= 1'b1;
            dmem_we       <= dmem_we;
            dmem_size     <= dmem_size;
            load_unsigned <= load_unsigned;
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef RV32I_CTRL_INSTRET_EN
  // Retired-instruction counter: one per WB cycle, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) instret <= 32'd0;
    else if (state_q == S_WB) instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: the driver pushes the expected
// EXEC/MEM/WB control sets per instruction; a negedge monitor pops and compares.
module tb_rv32i_multicycle_ctrl;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, alu_zero;
  logic        imem_req, ir_write, dmem_req, dmem_we, load_unsigned;
  logic [1:0]  dmem_size, alu_src_a, wb_sel, pc_sel;
  logic [4:0]  alu_op;
  logic        alu_src_b, reg_write, pc_write, illegal;
  logic [2:0]  state;

  rv32i_multicycle_ctrl #(.RESET_STATE_DELAY(0)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_size(dmem_size), .load_unsigned(load_unsigned), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [4:0] op;
    logic [1:0] sa;
    logic       sb;
    logic       we;
    logic [1:0] sz;
    logic       uns;
    int         mcyc;
    logic       rw;
    logic [1:0] wb;
    logic [1:0] pcs;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exec(input logic [4:0] op, input logic [1:0] sa, input logic sb);
    exp_t e = '{st: ST_EXEC, op: op, sa: sa, sb: sb, we: 0, sz: 0, uns: 0, mcyc: 0,
                rw: 0, wb: 0, pcs: 0};
    exp_q.push_back(e);
  endtask

  task automatic push_mem(input logic we, input logic [1:0] sz, input logic uns, input int mcyc);
    exp_t e = '{st: ST_MEM, op: 0, sa: 0, sb: 0, we: we, sz: sz, uns: uns, mcyc: mcyc,
                rw: 0, wb: 0, pcs: 0};
    exp_q.push_back(e);
  endtask

  task automatic push_wb(input logic rw, input logic [1:0] wb, input logic [1:0] pcs);
    exp_t e = '{st: ST_WB, op: 0, sa: 0, sb: 0, we: 0, sz: 0, uns: 0, mcyc: 0,
                rw: rw, wb: wb, pcs: pcs};
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expected record per EXEC, WB and MEM-entry cycle.
  logic [2:0] prev_state = ST_FETCH;
  int         mem_cnt = 0;
  int         cur_mcyc = -1;
  exp_t       e_mon;

  always @(negedge clk) begin
    prev_state <= state;
    if (state == ST_MEM) mem_cnt <= (prev_state == ST_MEM) ? mem_cnt + 1 : 1;
    if (!rst) begin
      if (prev_state == ST_MEM && state != ST_MEM && cur_mcyc >= 0)
        check("mem_req_cycles", mem_cnt, cur_mcyc);
      if (state == ST_EXEC || state == ST_WB || (state == ST_MEM && prev_state != ST_MEM)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got output in state %0d, expected none", state);
        end else begin
          e_mon = exp_q.pop_front();
          check("sb_state", state, e_mon.st);
          if (state == ST_EXEC) begin
            check("exec_alu_op", alu_op, e_mon.op);
            check("exec_src_a", alu_src_a, e_mon.sa);
            check("exec_src_b", alu_src_b, e_mon.sb);
          end else if (state == ST_MEM) begin
            cur_mcyc <= e_mon.mcyc;
            check("mem_dmem_req", dmem_req, 1'b1);
            check("mem_dmem_we", dmem_we, e_mon.we);
            check("mem_dmem_size", dmem_size, e_mon.sz);
            check("mem_load_unsigned", load_unsigned, e_mon.uns);
          end else begin
            check("wb_pc_write", pc_write, 1'b1);
            check("wb_reg_write", reg_write, e_mon.rw);
            check("wb_wb_sel", wb_sel, e_mon.wb);
            check("wb_pc_sel", pc_sel, e_mon.pcs);
          end
        end
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("imem_req_seen", imem_req, 1'b1);
  endtask

  // Present one instruction in FETCH and service the handshakes until FETCH or TRAP.
  task automatic issue(input logic [31:0] ins, input logic z, input int wait_n,
                       input int exp_cycles);
    int cyc = 0;
    int memc = 0;
    bit done = 0;
    wait_req();
    instr = ins;
    alu_zero = z;
    imem_ready = 1'b1;
    #1;
    check("ir_write", ir_write, 1'b1);
    while (!done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      imem_ready = 1'b0;
      if (state == ST_MEM) begin
        dmem_ready = (memc >= wait_n);
        memc++;
      end else begin
        dmem_ready = 1'b0;
      end
      if (state == ST_FETCH || state == ST_TRAP) done = 1;
    end
    check("latency_cycles", cyc, exp_cycles);
  endtask

  task automatic trap_and_recover(input logic [31:0] ins);
    int reqs = 0;
    issue(ins, 1'b0, 0, 2);
    check("trap_state", state, ST_TRAP);
    check("trap_illegal", illegal, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      if (imem_req) reqs++;
    end
    check("trap_no_fetch", reqs, 0);
    check("trap_held", state, ST_TRAP);
    rst = 1'b1;
    @(posedge clk); #1;
    check("trap_rst_state", state, ST_FETCH);
    check("trap_rst_illegal", illegal, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    instr = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    alu_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, ST_FETCH);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_alu_op", alu_op, 5'd0);
    check("rst_pc_write", pc_write, 1'b0);
    check("rst_reg_write", reg_write, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    rst = 1'b0;
    #1;
    check("first_imem_req", imem_req, 1'b1);

    // ADD x3,x1,x2
    push_exec(5'd2, 2'd0, 1'b0); push_wb(1'b1, 2'd0, 2'd0);
    issue(32'h002081B3, 1'b0, 0, 4);
    // SUB x3,x1,x2
    push_exec(5'd18, 2'd0, 1'b0); push_wb(1'b1, 2'd0, 2'd0);
    issue(32'h402081B3, 1'b0, 0, 4);
    // SRAI x1,x1,3
    push_exec(5'd17, 2'd0, 1'b1); push_wb(1'b1, 2'd0, 2'd0);
    issue(32'h4030D093, 1'b0, 0, 4);
    // BEQ taken / not taken
    push_exec(5'd3, 2'd0, 1'b0); push_wb(1'b0, 2'd0, 2'd2);
    issue(32'h00208463, 1'b1, 0, 4);
    push_exec(5'd3, 2'd0, 1'b0); push_wb(1'b0, 2'd0, 2'd0);
    issue(32'h00208463, 1'b0, 0, 4);
    // LHU x5,0(x1) with three dmem wait cycles
    push_exec(5'd2, 2'd0, 1'b1); push_mem(1'b0, 2'd1, 1'b1, 4); push_wb(1'b1, 2'd1, 2'd0);
    issue(32'h0000D283, 1'b0, 3, 8);
    // JAL x1,0
    push_exec(5'd2, 2'd1, 1'b1); push_wb(1'b1, 2'd2, 2'd1);
    issue(32'h000000EF, 1'b0, 0, 4);
    // LUI x1,1
    push_exec(5'd0, 2'd2, 1'b1); push_wb(1'b1, 2'd0, 2'd0);
    issue(32'h000010B7, 1'b0, 0, 4);
    // OR x3,x1,x2
    push_exec(5'd13, 2'd0, 1'b0); push_wb(1'b1, 2'd0, 2'd0);
    issue(32'h0020E1B3, 1'b0, 0, 4);
    // BLTU taken
    push_exec(5'd5, 2'd0, 1'b0); push_wb(1'b0, 2'd0, 2'd2);
    issue(32'h0020E463, 1'b1, 0, 4);
    // SW x2,0(x1), immediate dmem_ready
    push_exec(5'd2, 2'd0, 1'b1); push_mem(1'b1, 2'd2, 1'b0, 1); push_wb(1'b0, 2'd0, 2'd0);
    issue(32'h0020A023, 1'b0, 0, 5);

    // Illegal opcode, then SLLI with funct7[5] set
    trap_and_recover(32'h0000007F);
    trap_and_recover(32'h40109093);

    // SW aborted by reset during the dmem wait
    push_exec(5'd2, 2'd0, 1'b1); push_mem(1'b1, 2'd2, 1'b0, -1);
    wait_req();
    instr = 32'h0020A023;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_in_mem", state, ST_MEM);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_state", state, ST_FETCH);
    check("abort_dmem_req", dmem_req, 1'b0);
    check("abort_dmem_we", dmem_we, 1'b0);
    check("abort_pc_write", pc_write, 1'b0);
    check("abort_reg_write", reg_write, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_pc_write", pc_write, 1'b0);
    check("abort_refetch", imem_req, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback.
- It drives the 5-bit ALU opcode, the datapath muxes, the register-file and PC write strobes, and the instruction and data memory request handshakes.
- It sits beside the ALU, the register file and the instruction register. The immediate generator is external and is driven directly from instr.

Parameters:
- RESET_STATE_DELAY, 0, number of idle cycles held in FETCH after reset deassert before the first imem_req (0 to 3).

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction register output; valid from DECODE onward
- imem_ready  in  1  instruction memory data valid; loads the IR
- dmem_ready  in  1  data memory access complete
- alu_zero  in  1  ALU zero/compare flag
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (stores)
- dmem_size  out  2  access size: 0=byte, 1=half, 2=word
- load_unsigned  out  1  zero-extend load data (LBU, LHU)
- alu_op  out  5  ALU operation code
- alu_src_a  out  2  operand A select: 0=rs1, 1=pc, 2=zero
- alu_src_b  out  1  operand B select: 0=rs2, 1=immediate
- reg_write  out  1  register file write strobe
- wb_sel  out  2  writeback source: 0=ALU, 1=memory, 2=pc+4
- pc_write  out  1  PC update strobe
- pc_sel  out  2  next PC: 0=pc+4, 1=latched ALU result (JAL/JALR), 2=branch target
- illegal  out  1  sticky illegal-instruction flag
- state  out  3  current FSM state (debug)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset:
  - State goes to FETCH.
  - Every output strobe is 0, alu_op=0, all selects are 0, illegal=0.
  - Reset asserted in any state, including mid-memory wait, aborts the instruction on the next edge. Any pending req is dropped, with no write.
- FETCH:
  - imem_req=1 (after RESET_STATE_DELAY idle cycles following reset only).
  - Holds until imem_ready. In the ready cycle, ir_write=1 and the FSM moves to DECODE.
- DECODE: one cycle, decodes the opcode.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011. These go to EXEC.
  - Any other opcode goes to TRAP and sets illegal=1.
- EXEC: one cycle. alu_op is held stable for the whole cycle. Encoding:
  - LUI=0 (src_a=2, src_b=1); AUIPC=1 (src_a=1, src_b=1)
  - JAL=2 (src_a=1, src_b=1); JALR=2 (src_a=0, src_b=1)
  - loads and stores=2 (address, src_b=1)
  - BEQ=3, BNE=4, BLT/BLTU=5, BGE/BGEU=6 (src_b=0)
  - SLT/SLTU/SLTI/SLTIU=11, XOR=12, OR=13, AND=14, SLL=15, SRL=16, SRA=17 (funct7[5]=1), SUB=18 (R-type, funct7[5]=1); ADD/ADDI=2
  - I-type shifts with funct7[5]=1 on 001 are illegal and go to TRAP.
  - For branches, alu_zero is latched into internal taken.
  - Loads and stores go to MEM; everything else goes to WB.
- MEM:
  - dmem_req=1. dmem_we=1 for stores.
  - dmem_size comes from funct3[1:0]; load_unsigned=funct3[2].
  - Holds until dmem_ready, then goes to WB.
  - funct3 values 011, 110, 111 are illegal and trap in DECODE.
- WB: exactly one cycle.
  - pc_write=1.
  - reg_write=1 for LUI, AUIPC, JAL, JALR, loads, OP and OP-IMM. reg_write=0 for branches and stores.
  - wb_sel: 2 for JAL/JALR, 1 for loads, else 0.
  - pc_sel: 1 for JAL/JALR; 2 for a taken branch; else 0.
  - Then returns to FETCH.
- TRAP: all strobes are 0 and illegal=1. Held until rst.
- Strobes are Moore outputs decoded from state plus the latched instruction. The only exception is ir_write, which is gated by imem_ready.
- Simultaneous events: rst takes priority over ready and over TRAP entry. A ready arriving while in a non-waiting state is ignored.
- Latency: ALU/branch instructions take 3 cycles plus imem wait. Loads and stores take 4 cycles plus imem and dmem waits.

Optional Feature:
- Macro: RV32I_CTRL_INSTRET_EN.
- When defined:
  - Adds output instret[31:0], reset to 0.
  - Increments by 1 in every WB cycle and wraps 0xFFFFFFFF to 0.
  - It does not increment in TRAP.
- When undefined: the port and counter are absent. FSM timing is identical in both builds.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ready in first cycle -> EXEC alu_op=2, src_b=0. WB reg_write=1, wb_sel=0, pc_sel=0. 4 cycles from FETCH to FETCH.
- SUB (0x402081B3) -> alu_op=18. SRAI x1,x1,3 (0x4030D093) -> alu_op=17, src_b=1.
- BEQ with alu_zero=1 in EXEC -> WB pc_sel=2, reg_write=0. Repeat with alu_zero=0 -> pc_sel=0.
- LHU (funct3=101), dmem_ready held low 3 cycles -> dmem_req held 4 cycles, dmem_size=1, load_unsigned=1. WB wb_sel=1.
- Opcode 0x0000007F -> DECODE to TRAP, illegal=1, no further imem_req. rst pulse -> FETCH, illegal=0.
- rst asserted during a MEM wait for SW -> next cycle state=FETCH, dmem_req=0, dmem_we=0, no pc_write.
